// File: rtl/commit_exception_unit_pkg.sv
// Shared types and constants for the commit-end exception unit.
package commit_exception_unit_pkg;

    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic       ex;
        logic [4:0] exccode;
        virt_t      epc;
        virt_t      badvaddr;
    } exception_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } commit_state_t;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_MOD  = 5'h01;
    localparam logic [4:0] EXCCODE_TLBL = 5'h02;
    localparam logic [4:0] EXCCODE_TLBS = 5'h03;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0A;
    localparam logic [4:0] EXCCODE_CPU  = 5'h0B;
    localparam logic [4:0] EXCCODE_OV   = 5'h0C;

    localparam virt_t VEC_BEV_DFLT    = 32'hBFC00380;
    localparam virt_t VEC_NORMAL_DFLT = 32'h80000180;

endpackage

// File: rtl/commit_exception_unit_exc_target_sel.sv
// Picks the redirect target and CP0 write fields for a committing instruction.
module exc_target_sel
    import commit_exception_unit_pkg::*;
#(
    parameter virt_t VEC_BEV    = VEC_BEV_DFLT,
    parameter virt_t VEC_NORMAL = VEC_NORMAL_DFLT
) (
    input  exception_t  exc,
    input  logic        is_eret,
    input  logic        is_priv,
    input  logic        in_ds,
    input  virt_t       pc,
    input  logic        status_exl,
    input  logic        status_bev,
    input  virt_t       cp0_epc,
    output logic        event_c,
    output logic        exc_we_c,
    output logic        epc_we_c,
    output logic        eret_we_c,
    output logic [4:0]  exccode_c,
    output logic        bd_c,
    output virt_t       epc_wdata_c,
    output virt_t       badvaddr_c,
    output virt_t       target_c
);

    // Priority: exception > ERET > privileged refetch.
    always_comb begin
        event_c     = exc.ex | is_eret | is_priv;
        exc_we_c    = exc.ex;
        epc_we_c    = exc.ex & ~status_exl;
        eret_we_c   = ~exc.ex & is_eret;
        exccode_c   = exc.exccode;
        bd_c        = in_ds;
        epc_wdata_c = in_ds ? (pc - 32'd4) : pc;
        badvaddr_c  = exc.badvaddr;
        target_c    = '0;
        if (exc.ex) begin
            target_c = status_bev ? VEC_BEV : VEC_NORMAL;
        end else if (is_eret) begin
            target_c = cp0_epc;
        end else if (is_priv) begin
            target_c = exc.epc;
        end
    end

endmodule

// File: rtl/commit_exception_unit.sv
// Commit-end exception handling: CP0 state writes, pipeline flush and fetch redirect.
module commit_exception_unit
    import commit_exception_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter virt_t       VEC_BEV      = VEC_BEV_DFLT,
    parameter virt_t       VEC_NORMAL   = VEC_NORMAL_DFLT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  exception_t  commit_exc,
    input  logic        commit_is_eret,
    input  logic        commit_is_priv,
    input  logic        commit_in_ds,
    input  logic        status_exl,
    input  logic        status_bev,
    input  logic [31:0] cp0_epc,
    output logic        cp0_exc_we,
    output logic [4:0]  cp0_exccode,
    output logic        cp0_bd,
    output logic [31:0] cp0_epc_wdata,
    output logic        cp0_epc_we,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_eret_we,
    output logic        flush,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    commit_state_t    state;
    logic [CNT_W-1:0] cnt;
    virt_t            target;

    logic       event_c;
    logic       exc_we_c;
    logic       epc_we_c;
    logic       eret_we_c;
    logic [4:0] exccode_c;
    logic       bd_c;
    virt_t      epc_wdata_c;
    virt_t      badvaddr_c;
    virt_t      target_c;

    exc_target_sel #(
        .VEC_BEV    (VEC_BEV),
        .VEC_NORMAL (VEC_NORMAL)
    ) u_sel (
        .exc         (commit_exc),
        .is_eret     (commit_is_eret),
        .is_priv     (commit_is_priv),
        .in_ds       (commit_in_ds),
        .pc          (commit_pc),
        .status_exl  (status_exl),
        .status_bev  (status_bev),
        .cp0_epc     (cp0_epc),
        .event_c     (event_c),
        .exc_we_c    (exc_we_c),
        .epc_we_c    (epc_we_c),
        .eret_we_c   (eret_we_c),
        .exccode_c   (exccode_c),
        .bd_c        (bd_c),
        .epc_wdata_c (epc_wdata_c),
        .badvaddr_c  (badvaddr_c),
        .target_c    (target_c)
    );

    // CP0 write enables are single-cycle pulses; data fields hold until the next exception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            target         <= '0;
            commit_ready   <= 1'b1;
            cp0_exc_we     <= 1'b0;
            cp0_exccode    <= '0;
            cp0_bd         <= 1'b0;
            cp0_epc_wdata  <= '0;
            cp0_epc_we     <= 1'b0;
            cp0_badvaddr   <= '0;
            cp0_eret_we    <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            cp0_exc_we  <= 1'b0;
            cp0_epc_we  <= 1'b0;
            cp0_eret_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_valid && event_c) begin
                        state        <= FLUSH;
                        cnt          <= CNT_W'(FLUSH_CYCLES - 1);
                        target       <= target_c;
                        commit_ready <= 1'b0;
                        flush        <= 1'b1;
                        cp0_exc_we   <= exc_we_c;
                        cp0_epc_we   <= epc_we_c;
                        cp0_eret_we  <= eret_we_c;
                        if (exc_we_c) begin
                            cp0_exccode   <= exccode_c;
                            cp0_bd        <= bd_c;
                            cp0_epc_wdata <= epc_wdata_c;
                            cp0_badvaddr  <= badvaddr_c;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state          <= REDIRECT;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        commit_ready   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_commit_exception_unit.sv
// Directed self-checking bench for commit_exception_unit.
module tb_commit_exception_unit;
    import commit_exception_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    exception_t  commit_exc;
    logic        commit_is_eret;
    logic        commit_is_priv;
    logic        commit_in_ds;
    logic        status_exl;
    logic        status_bev;
    logic [31:0] cp0_epc;
    logic        cp0_exc_we;
    logic [4:0]  cp0_exccode;
    logic        cp0_bd;
    logic [31:0] cp0_epc_wdata;
    logic        cp0_epc_we;
    logic [31:0] cp0_badvaddr;
    logic        cp0_eret_we;
    logic        flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    commit_exception_unit dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_pc      (commit_pc),
        .commit_exc     (commit_exc),
        .commit_is_eret (commit_is_eret),
        .commit_is_priv (commit_is_priv),
        .commit_in_ds   (commit_in_ds),
        .status_exl     (status_exl),
        .status_bev     (status_bev),
        .cp0_epc        (cp0_epc),
        .cp0_exc_we     (cp0_exc_we),
        .cp0_exccode    (cp0_exccode),
        .cp0_bd         (cp0_bd),
        .cp0_epc_wdata  (cp0_epc_wdata),
        .cp0_epc_we     (cp0_epc_we),
        .cp0_badvaddr   (cp0_badvaddr),
        .cp0_eret_we    (cp0_eret_we),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc)
    );

    // Present one commit at a negedge; the next negedge is cycle C+1.
    task automatic do_commit(input logic [31:0] pc, input exception_t exc,
                             input logic eret, input logic priv, input logic ds);
        @(negedge clk);
        commit_valid   = 1'b1;
        commit_pc      = pc;
        commit_exc     = exc;
        commit_is_eret = eret;
        commit_is_priv = priv;
        commit_in_ds   = ds;
        @(negedge clk);
        commit_valid   = 1'b0;
        commit_is_eret = 1'b0;
        commit_is_priv = 1'b0;
        commit_exc     = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", commit_ready); end
        n_checks++; if ({cp0_exc_we, cp0_epc_we, cp0_eret_we, flush, redirect_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 00000", {cp0_exc_we, cp0_epc_we, cp0_eret_we, flush, redirect_valid}); end
        n_checks++; if (redirect_pc !== 32'h0 || cp0_epc_wdata !== 32'h0 || cp0_badvaddr !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h/%h/%h want 0", redirect_pc, cp0_epc_wdata, cp0_badvaddr); end
        reset = 1'b0;
    endtask

    task automatic test_no_event;
        do_commit(32'h80000500, '0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (commit_ready !== 1'b1 || flush !== 1'b0 || cp0_exc_we !== 1'b0) begin n_fail++; $display("FAIL noevent got ready=%b flush=%b exc_we=%b want 1/0/0", commit_ready, flush, cp0_exc_we); end
    endtask

    task automatic test_exc_ri;
        status_exl = 1'b0; status_bev = 1'b0;
        redirect_ready = 1'b1; // ready held high throughout: must not shorten the flush
        do_commit(32'h80001000, '{ex: 1'b1, exccode: EXCCODE_RI, epc: 32'h0, badvaddr: 32'h0}, 1'b0, 1'b0, 1'b0);
        n_checks++; if (cp0_exc_we !== 1'b1 || cp0_epc_we !== 1'b1 || cp0_eret_we !== 1'b0) begin n_fail++; $display("FAIL ri_we got exc=%b epc=%b eret=%b want 1/1/0", cp0_exc_we, cp0_epc_we, cp0_eret_we); end
        n_checks++; if (cp0_exccode !== 5'h0A) begin n_fail++; $display("FAIL ri_exccode got %h want 0a", cp0_exccode); end
        n_checks++; if (cp0_epc_wdata !== 32'h80001000 || cp0_bd !== 1'b0) begin n_fail++; $display("FAIL ri_epc got %h bd=%b want 80001000 bd=0", cp0_epc_wdata, cp0_bd); end
        n_checks++; if (flush !== 1'b1 || commit_ready !== 1'b0) begin n_fail++; $display("FAIL ri_flush1 got flush=%b ready=%b want 1/0", flush, commit_ready); end
        @(negedge clk);
        n_checks++; if (cp0_exc_we !== 1'b0 || flush !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL ri_flush2 got exc_we=%b flush=%b rv=%b want 0/1/0", cp0_exc_we, flush, redirect_valid); end
        @(negedge clk);
        n_checks++; if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h80000180) begin n_fail++; $display("FAIL ri_redirect got flush=%b rv=%b pc=%h want 0/1/80000180", flush, redirect_valid, redirect_pc); end
        @(negedge clk);
        n_checks++; if (redirect_valid !== 1'b0 || commit_ready !== 1'b1) begin n_fail++; $display("FAIL ri_idle got rv=%b ready=%b want 0/1", redirect_valid, commit_ready); end
        redirect_ready = 1'b0;
    endtask

    task automatic test_exc_sys_ds;
        status_exl = 1'b0; status_bev = 1'b1;
        do_commit(32'h80002004, '{ex: 1'b1, exccode: EXCCODE_SYS, epc: 32'h0, badvaddr: 32'h0}, 1'b0, 1'b0, 1'b1);
        status_bev = 1'b0; // target must have been sampled at commit time
        n_checks++; if (cp0_epc_wdata !== 32'h80002000 || cp0_bd !== 1'b1 || cp0_exccode !== 5'h08) begin n_fail++; $display("FAIL sys_epc got %h bd=%b code=%h want 80002000 bd=1 code=08", cp0_epc_wdata, cp0_bd, cp0_exccode); end
        repeat (2) @(negedge clk);
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC00380) begin n_fail++; $display("FAIL sys_redirect got rv=%b pc=%h want 1/bfc00380", redirect_valid, redirect_pc); end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        n_checks++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL sys_idle got ready=%b want 1", commit_ready); end
    endtask

    task automatic test_exc_exl;
        status_exl = 1'b1; status_bev = 1'b0;
        do_commit(32'h80005000, '{ex: 1'b1, exccode: EXCCODE_ADEL, epc: 32'h0, badvaddr: 32'h12345679}, 1'b0, 1'b0, 1'b0);
        status_exl = 1'b0;
        n_checks++; if (cp0_exc_we !== 1'b1 || cp0_epc_we !== 1'b0) begin n_fail++; $display("FAIL exl_we got exc=%b epc=%b want 1/0", cp0_exc_we, cp0_epc_we); end
        n_checks++; if (cp0_badvaddr !== 32'h12345679 || cp0_exccode !== 5'h04) begin n_fail++; $display("FAIL exl_bad got %h code=%h want 12345679 code=04", cp0_badvaddr, cp0_exccode); end
        repeat (2) @(negedge clk);
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000180) begin n_fail++; $display("FAIL exl_redirect got rv=%b pc=%h want 1/80000180", redirect_valid, redirect_pc); end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
    endtask

    task automatic test_eret;
        cp0_epc = 32'h80003000;
        do_commit(32'h80006000, '0, 1'b1, 1'b0, 1'b0);
        cp0_epc = 32'h0;
        n_checks++; if (cp0_eret_we !== 1'b1 || cp0_exc_we !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL eret_we got eret=%b exc=%b flush=%b want 1/0/1", cp0_eret_we, cp0_exc_we, flush); end
        @(negedge clk);
        n_checks++; if (cp0_eret_we !== 1'b0) begin n_fail++; $display("FAIL eret_pulse got %b want 0", cp0_eret_we); end
        @(negedge clk);
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80003000) begin n_fail++; $display("FAIL eret_redirect got rv=%b pc=%h want 1/80003000", redirect_valid, redirect_pc); end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
    endtask

    task automatic test_priv_stall;
        do_commit(32'h80004004, '{ex: 1'b0, exccode: 5'h0, epc: 32'h80004008, badvaddr: 32'h0}, 1'b0, 1'b1, 1'b0);
        n_checks++; if (cp0_exc_we !== 1'b0 || cp0_eret_we !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL priv_nocp0 got exc=%b eret=%b flush=%b want 0/0/1", cp0_exc_we, cp0_eret_we, flush); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80004008 || commit_ready !== 1'b0) begin n_fail++; $display("FAIL priv_hold%0d got rv=%b pc=%h ready=%b want 1/80004008/0", i, redirect_valid, redirect_pc, commit_ready); end
            commit_valid = (i == 1);
            commit_exc   = (i == 1) ? '{ex: 1'b1, exccode: EXCCODE_OV, epc: 32'h0, badvaddr: 32'h0} : '0;
        end
        commit_valid = 1'b0;
        commit_exc   = '0;
        @(negedge clk);
        n_checks++; if (cp0_exc_we !== 1'b0 || redirect_pc !== 32'h80004008) begin n_fail++; $display("FAIL priv_ignored got exc=%b pc=%h want 0/80004008", cp0_exc_we, redirect_pc); end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        n_checks++; if (commit_ready !== 1'b1 || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL priv_idle got ready=%b rv=%b want 1/0", commit_ready, redirect_valid); end
    endtask

    task automatic test_priority_wrap;
        status_exl = 1'b0; status_bev = 1'b1; cp0_epc = 32'h80007000;
        do_commit(32'h00000000, '{ex: 1'b1, exccode: EXCCODE_INT, epc: 32'h80008000, badvaddr: 32'h0}, 1'b1, 1'b1, 1'b1);
        n_checks++; if (cp0_exc_we !== 1'b1 || cp0_eret_we !== 1'b0 || cp0_exccode !== 5'h00) begin n_fail++; $display("FAIL prio_we got exc=%b eret=%b code=%h want 1/0/00", cp0_exc_we, cp0_eret_we, cp0_exccode); end
        n_checks++; if (cp0_epc_wdata !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_epc got %h want fffffffc", cp0_epc_wdata); end
        repeat (2) @(negedge clk);
        n_checks++; if (redirect_pc !== 32'hBFC00380) begin n_fail++; $display("FAIL prio_redirect got %h want bfc00380", redirect_pc); end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        status_bev = 1'b0;
    endtask

    task automatic test_reset_mid_flush;
        do_commit(32'h80009000, '{ex: 1'b1, exccode: EXCCODE_BP, epc: 32'h0, badvaddr: 32'h0}, 1'b0, 1'b0, 1'b0);
        commit_valid = 1'b1;
        commit_exc   = '{ex: 1'b1, exccode: EXCCODE_RI, epc: 32'h0, badvaddr: 32'h0};
        @(negedge clk);
        commit_valid = 1'b0;
        commit_exc   = '0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (commit_ready !== 1'b1 || flush !== 1'b0 || redirect_valid !== 1'b0 || cp0_exc_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid got ready=%b flush=%b rv=%b exc=%b want 1/0/0/0", commit_ready, flush, redirect_valid, cp0_exc_we); end
        n_checks++; if (cp0_exccode !== 5'h0 || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data got code=%h pc=%h want 0/0", cp0_exccode, redirect_pc); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || cp0_exc_we !== 1'b0 || commit_ready !== 1'b1) begin n_fail++; $display("FAIL rst_quiet%0d got flush=%b rv=%b exc=%b ready=%b want 0/0/0/1", i, flush, redirect_valid, cp0_exc_we, commit_ready); end
        end
    endtask

    initial begin
        reset          = 1'b1;
        commit_valid   = 1'b0;
        commit_pc      = '0;
        commit_exc     = '0;
        commit_is_eret = 1'b0;
        commit_is_priv = 1'b0;
        commit_in_ds   = 1'b0;
        status_exl     = 1'b0;
        status_bev     = 1'b0;
        cp0_epc        = '0;
        redirect_ready = 1'b0;
        test_reset();
        test_no_event();
        test_exc_ri();
        test_exc_sys_ds();
        test_exc_exl();
        test_eret();
        test_priv_stall();
        test_priority_wrap();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
